fir_stream_ctrl: RTL and testbench

- Sequencer between the tile I/O pins and the FIR datapath.
- Paces input samples with a programmable sample-rate divider.
- Pushes each sample into the FIR's AXI-stream slave port, then waits for the filtered result.
- Scales and saturates the result back to 8 bits, and holds the FIR coefficient register bank loaded from the pins.

---
 rtl/fir_pkg.sv | 32 +++
 rtl/fir_stream_ctrl_if.sv | 30 +++
 rtl/fir_rate_div.sv | 35 +++
 rtl/fir_stream_ctrl.sv | 140 ++++++++++++++
 tb/tb_fir_stream_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR stream controller slice:
// state encoding, default geometry and the 8-bit output saturation helper.
package fir_pkg;

    localparam int NTAPS  = 4;
    localparam int COEF_W = 8;
    localparam int OUT_W  = 18;
    localparam int SHIFT  = 7;
    localparam int DIV_W  = 24;

    localparam logic [DIV_W-1:0] DEFAULT_DIV = 24'd10_000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND,
        RECV
    } state_t;

    // Input is the already-shifted FIR result; clamp into the signed 8-bit range.
    function automatic logic signed [7:0] sat8(input logic signed [OUT_W-SHIFT-1:0] v);
        logic signed [7:0] r;
        if (v > 127)
            r = 8'h7F;
        else if (v < -128)
            r = 8'h80;
        else
            r = v[7:0];
        return r;
    endfunction

endpackage

// File: rtl/fir_stream_ctrl_if.sv
// Stream link between the controller and the FIR datapath: sample channel
// towards the FIR and result channel back from it.
interface fir_stream_ctrl_if #(
    parameter int RES_W = fir_pkg::OUT_W
);

    logic [7:0]              s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic signed [RES_W-1:0] m_axis_tdata;
    logic                    m_axis_tvalid;

    // master: the sequencer side; slave: the FIR side
    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid
    );

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid
    );

endinterface

// File: rtl/fir_rate_div.sv
// 24-bit sample-rate divider: counts up to a selectable compare value and
// emits a one-cycle tick on the compare cycle.
module fir_rate_div
    import fir_pkg::*;
#(
    parameter logic [DIV_W-1:0] DEF_DIV = DEFAULT_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [7:0] div_sel,
    output logic       tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cmp;

    // Compare is re-evaluated every cycle, so a new div_sel applies at the next match;
    // a counter already past it simply wraps through 2^24.
    always_comb begin
        cmp = (div_sel == 8'd0) ? DEF_DIV : {6'b0, div_sel, 10'b0};
    end

    assign tick = run && (cnt == cmp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!run || (cnt == cmp))
            cnt <= '0;
        else
            cnt <= cnt + DIV_W'(1);
    end

endmodule

// File: rtl/fir_stream_ctrl.sv
// Sequencer between tile pins and the FIR: paces samples, runs the stream
// handshake, scales/saturates the result and holds the coefficient bank.
module fir_stream_ctrl
    import fir_pkg::*;
#(
    parameter int               NTAPS       = fir_pkg::NTAPS,
    parameter int               COEF_W      = fir_pkg::COEF_W,
    parameter int               OUT_W       = fir_pkg::OUT_W,
    parameter int               SHIFT       = fir_pkg::SHIFT,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = fir_pkg::DEFAULT_DIV
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [7:0]              div_sel,
    input  logic [7:0]              smp_in,
    input  logic                    coef_wr,
    input  logic [1:0]              coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    output logic [NTAPS*COEF_W-1:0] coef_bus,
    fir_stream_ctrl_if.master       ax,
    output logic signed [7:0]       y_out,
    output logic                    y_valid,
    output logic                    overrun,
    output logic                    coef_err,
    output logic                    busy
);

    state_t state;
    state_t state_nx;

    logic run;
    logic tick;
    logic load_smp;
    logic res_hit;
    logic [7:0] smp_p0;
    logic signed [OUT_W-SHIFT-1:0] res_sh;
    logic unused_lsb;

    // The divider keeps running through an in-flight transaction even if ena drops.
    assign run = ena || (state != IDLE);

    fir_rate_div #(
        .DEF_DIV (DEFAULT_DIV)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .div_sel (div_sel),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx         = state;
        load_smp         = 1'b0;
        res_hit          = 1'b0;
        ax.s_axis_tvalid = 1'b0;
        busy             = 1'b0;
        case (state)
            IDLE: begin
                if (ena)
                    state_nx = WAIT;
            end
            WAIT: begin
                if (tick) begin
                    state_nx = SEND;
                    load_smp = 1'b1;
                end else if (!ena) begin
                    state_nx = IDLE;
                end
            end
            SEND: begin
                ax.s_axis_tvalid = 1'b1;
                busy             = 1'b1;
                if (ax.s_axis_tready)
                    state_nx = RECV;
            end
            RECV: begin
                busy = 1'b1;
                if (ax.m_axis_tvalid) begin
                    res_hit  = 1'b1;
                    state_nx = ena ? WAIT : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: sample captured on the tick, held stable for the whole SEND phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            smp_p0 <= '0;
        else if (load_smp)
            smp_p0 <= smp_in;
    end

    assign ax.s_axis_tdata = smp_p0;

    // Dropping the low SHIFT bits of a two's-complement value is an arithmetic shift.
    assign res_sh     = ax.m_axis_tdata[OUT_W-1:SHIFT];
    assign unused_lsb = ^ax.m_axis_tdata[SHIFT-1:0];

    // Stage p1: saturated result and its strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= res_hit;
            if (res_hit)
                y_out <= sat8(res_sh);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun  <= 1'b0;
            coef_err <= 1'b0;
        end else begin
            overrun  <= overrun  | (tick & busy);
            coef_err <= coef_err | (coef_wr & busy);
        end
    end

    // The bank is only writable while no sample is in flight to the FIR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            coef_bus <= '0;
        else if (coef_wr && !busy)
            coef_bus[coef_addr*COEF_W +: COEF_W] <= coef_data;
    end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed-plus-random bench for fir_stream_ctrl with a behavioural FIR
// responder and a reference model for scaling, pacing and the coefficient bank.
module tb_fir_stream_ctrl;
    import fir_pkg::*;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              ena       = 1'b0;
    logic [7:0]        div_sel   = 8'd0;
    logic [7:0]        smp_in    = 8'd0;
    logic              coef_wr   = 1'b0;
    logic [1:0]        coef_addr = 2'd0;
    logic [7:0]        coef_data = 8'd0;
    logic [31:0]       coef_bus;
    logic signed [7:0] y_out;
    logic              y_valid;
    logic              overrun;
    logic              coef_err;
    logic              busy;

    fir_stream_ctrl_if ax ();

    fir_stream_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .div_sel   (div_sel),
        .smp_in    (smp_in),
        .coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_bus  (coef_bus),
        .ax        (ax),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .overrun   (overrun),
        .coef_err  (coef_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         tests     = 0;
    int         fails     = 0;
    int         cyc_n     = 0;
    int         last_rise = -1;
    int         yv_cnt    = 0;
    int         fir_delay = 2;
    int         fir_ret   = 0;
    bit         chk_period = 1'b0;
    bit         bp_chk     = 1'b0;
    bit         tv_prev    = 1'b0;
    logic [7:0] smp_at_edge = 8'd0;
    logic [7:0] held_tdata  = 8'd0;
    logic [7:0] exp_q[$];
    logic [7:0] coef_m[4];

    // floor(m / 2^7) then clamp to the signed byte range
    function automatic logic [7:0] ref_y(int m);
        int q;
        q = m / 128;
        if (m < 0 && (m % 128) != 0)
            q = q - 1;
        if (q > 127)
            q = 127;
        if (q < -128)
            q = -128;
        return q[7:0];
    endfunction

    function automatic int period_of(logic [7:0] ds);
        return (ds == 8'd0) ? 10001 : int'(ds) * 1024 + 1;
    endfunction

    function automatic logic [31:0] pack_coef();
        return {coef_m[3], coef_m[2], coef_m[1], coef_m[0]};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample smp_in at the edge, observe outputs on the falling edge.
    task automatic cyc();
        @(posedge clk);
        smp_at_edge = smp_in;
        @(negedge clk);
        cyc_n++;
        if (ax.s_axis_tvalid && !tv_prev) begin
            chk("tdata_latch", {24'd0, ax.s_axis_tdata}, {24'd0, smp_at_edge});
            if (chk_period && last_rise >= 0)
                chk("tick_period", cyc_n - last_rise, period_of(div_sel));
            last_rise  = cyc_n;
            held_tdata = ax.s_axis_tdata;
        end
        if (bp_chk) begin
            chk("bp_tvalid", 32'(ax.s_axis_tvalid), 32'd1);
            chk("bp_tdata", {24'd0, ax.s_axis_tdata}, {24'd0, held_tdata});
        end
        if (y_valid) begin
            yv_cnt++;
            chk("y_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0)
                chk("y_out", {24'd0, y_out}, {24'd0, exp_q.pop_front()});
        end
        tv_prev = ax.s_axis_tvalid;
        smp_in  = 8'($urandom);
    endtask

    task automatic wait_y(int bound);
        int n = 0;
        while (yv_cnt == 0 && n < bound) begin
            cyc();
            n++;
        end
        chk("y_seen", 32'(yv_cnt > 0), 32'd1);
    endtask

    task automatic wait_tvalid(int bound);
        int n = 0;
        while (!ax.s_axis_tvalid && n < bound) begin
            cyc();
            n++;
        end
        chk("tvalid_seen", 32'(ax.s_axis_tvalid), 32'd1);
    endtask

    task automatic run_txn(int val);
        yv_cnt  = 0;
        fir_ret = val;
        wait_y(3000);
        repeat (3) cyc();
        chk("y_once", yv_cnt, 32'd1);
    endtask

    // FIR responder: result returns fir_delay cycles after each handshake
    initial begin
        ax.m_axis_tvalid = 1'b0;
        ax.m_axis_tdata  = '0;
        forever begin
            @(posedge clk);
            if (rst_n && ax.s_axis_tvalid && ax.s_axis_tready) begin
                repeat (fir_delay - 1) @(posedge clk);
                @(negedge clk);
                ax.m_axis_tdata  = 18'(fir_ret);
                ax.m_axis_tvalid = 1'b1;
                exp_q.push_back(ref_y(fir_ret));
                @(negedge clk);
                ax.m_axis_tvalid = 1'b0;
            end
        end
    end

    initial begin
        int c0;
        int rise_before;
        ax.s_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++)
            coef_m[i] = 8'd0;

        repeat (3) @(negedge clk);
        chk("rst_y_out", {24'd0, y_out}, 32'd0);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_coef_err", 32'(coef_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tvalid", 32'(ax.s_axis_tvalid), 32'd0);
        chk("rst_coef_bus", coef_bus, 32'd0);
        chk("rst_cnt", 32'(dut.u_div.cnt), 32'd0);

        rst_n = 1'b1;
        cyc();
        ena     = 1'b1;
        div_sel = 8'd1;
        cyc();
        chk("state_wait", 32'(dut.state), 32'(WAIT));

        for (int i = 0; i < 4; i++) begin
            coef_wr   = 1'b1;
            coef_addr = 2'(i);
            coef_data = 8'(8'h11 * (i + 1));
            coef_m[i] = coef_data;
            cyc();
        end
        coef_wr = 1'b0;
        cyc();
        chk("coef_bus_wait", coef_bus, 32'h44332211);
        chk("coef_err_clear", 32'(coef_err), 32'd0);

        chk_period = 1'b1;
        run_txn(12800);
        run_txn(12800);
        run_txn(40000);
        run_txn(-40000);
        run_txn(-256);

        for (int k = 0; k < 4; k++) begin
            run_txn(int'($urandom_range(262143)) - 131072);
            coef_wr   = 1'b1;
            coef_addr = 2'($urandom_range(3));
            coef_data = 8'($urandom);
            coef_m[coef_addr] = coef_data;
            cyc();
            coef_wr = 1'b0;
            cyc();
            chk("coef_bus_rand", coef_bus, pack_coef());
        end

        div_sel = 8'd2;
        run_txn(int'($urandom_range(262143)) - 131072);
        run_txn(int'($urandom_range(262143)) - 131072);
        div_sel = 8'd1;
        run_txn(int'($urandom_range(262143)) - 131072);

        // Coefficient write while the result is outstanding must be refused
        fir_delay = 10;
        yv_cnt    = 0;
        fir_ret   = int'($urandom_range(262143)) - 131072;
        begin
            int n = 0;
            while (!(busy && !ax.s_axis_tvalid) && n < 3000) begin
                cyc();
                n++;
            end
            chk("recv_seen", 32'(busy && !ax.s_axis_tvalid), 32'd1);
        end
        coef_wr   = 1'b1;
        coef_addr = 2'd2;
        coef_data = 8'hFF;
        cyc();
        coef_wr = 1'b0;
        cyc();
        chk("coef_bus_recv", coef_bus, pack_coef());
        chk("coef_err_set", 32'(coef_err), 32'd1);
        wait_y(50);
        repeat (3) cyc();
        chk("y_once_recv", yv_cnt, 32'd1);
        fir_delay = 2;

        // Backpressure: sample must be held until the first ready cycle
        chk_period       = 1'b0;
        ax.s_axis_tready = 1'b0;
        fir_ret          = int'($urandom_range(262143)) - 131072;
        yv_cnt           = 0;
        wait_tvalid(3000);
        bp_chk = 1'b1;
        repeat (50) cyc();
        bp_chk = 1'b0;
        chk("overrun_bp50", 32'(overrun), 32'd0);
        ax.s_axis_tready = 1'b1;
        cyc();
        chk("hs_first_ready", 32'(ax.s_axis_tvalid), 32'd0);
        chk("hs_busy_recv", 32'(busy), 32'd1);
        wait_y(50);
        repeat (3) cyc();
        chk("y_once_bp", yv_cnt, 32'd1);

        // Hold SEND across a full divider period so a tick is dropped
        ax.s_axis_tready = 1'b0;
        yv_cnt           = 0;
        wait_tvalid(3000);
        bp_chk = 1'b1;
        repeat (1100) cyc();
        bp_chk = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        ax.s_axis_tready = 1'b1;
        wait_y(50);
        repeat (20) cyc();
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // ena dropped while SEND: transaction completes, then FSM parks in IDLE
        yv_cnt = 0;
        wait_tvalid(3000);
        ena = 1'b0;
        wait_y(50);
        repeat (3) cyc();
        chk("y_once_enadrop", yv_cnt, 32'd1);
        chk("enadrop_busy", 32'(busy), 32'd0);
        chk("enadrop_state", 32'(dut.state), 32'(IDLE));
        chk("enadrop_cnt", 32'(dut.u_div.cnt), 32'd0);
        rise_before = last_rise;
        repeat (1100) cyc();
        chk("idle_no_tick", last_rise, rise_before);
        chk("idle_cnt", 32'(dut.u_div.cnt), 32'd0);

        // Restart from a held-zero divider: first sample one full period later
        ax.s_axis_tready = 1'b0;
        c0  = cyc_n;
        ena = 1'b1;
        wait_tvalid(3000);
        chk("restart_period", last_rise - c0, period_of(div_sel));
        chk("exp_q_empty", exp_q.size(), 32'd0);

        // Asynchronous reset while SEND with tvalid high
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", 32'(ax.s_axis_tvalid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_state", 32'(dut.state), 32'(IDLE));
        chk("arst_coef_bus", coef_bus, 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        chk("arst_coef_err", 32'(coef_err), 32'd0);
        chk("arst_y_out", {24'd0, y_out}, 32'd0);
        chk("arst_tdata", {24'd0, ax.s_axis_tdata}, 32'd0);
        chk("arst_cnt", 32'(dut.u_div.cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
